// File: rtl/clk_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_pattern_pkg
//  Description : Shared definitions for the clock-pattern player: FSM state
//                encoding and default parameter values.
//  Contents    : state_t  - player FSM states (IDLE, START_REQ, LOAD, SEND)
//                c_DEF_*  - default values for the player parameters
//  Revision    : 1.0 - initial release
// ============================================================================
package clk_pattern_pkg;

    localparam int unsigned c_DEF_DATA_WIDTH = 8;
    localparam int unsigned c_DEF_NUM_CH     = 2;
    localparam int unsigned c_DEF_DEPTH      = 64;
    localparam int unsigned c_DEF_REP_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START_REQ = 2'd1,
        ST_LOAD      = 2'd2,
        ST_SEND      = 2'd3
    } state_t;

endpackage : clk_pattern_pkg
`default_nettype wire

// File: rtl/clk_pattern_ram.sv
`default_nettype none
// ============================================================================
//  Module      : clk_pattern_ram
//  Description : Simple dual-port pattern buffer. One synchronous write port,
//                one registered read port (1-cycle latency). The read register
//                only updates when i_rd_en is high, so its output holds the
//                last word read otherwise.
//  Ports       : i_clk, i_rst_n        - clock, sync active-low reset (read reg)
//                i_wr_en/addr/data     - write port
//                i_rd_en/addr          - read request
//                o_rd_data             - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_pattern_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 64,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage array carries no reset so it maps onto plain block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : clk_pattern_ram
`default_nettype wire

// File: rtl/clk_pattern_player.sv
`default_nettype none
// ============================================================================
//  Module      : clk_pattern_player
//  Description : Loads a pattern of words from a valid/ready stream into a
//                buffer, then replays bits [NUM_CH-1:0] of each word on
//                o_lanes, (repeat+1) times back to back. Re-arms for a new
//                load after reset or after an i_output_last pulse.
//  Ports       : i_clk, i_rst_n                 - clock, sync active-low reset
//                i_tdata_valid/i_tdata/
//                i_tdata_last/o_tready          - pattern load stream
//                i_repeat                       - extra replays (on last beat)
//                i_output_last                  - consumer done, re-arms load
//                o_lanes/o_enb                  - replayed pattern + valid
//                o_busy                         - not in IDLE
//                o_overflow                     - sticky: beats were dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_pattern_player
    import clk_pattern_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int unsigned NUM_CH     = c_DEF_NUM_CH,
    parameter int unsigned DEPTH      = c_DEF_DEPTH,
    parameter int unsigned REP_WIDTH  = c_DEF_REP_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tdata_valid,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic                  i_tdata_last,
    input  logic [REP_WIDTH-1:0]  i_repeat,
    input  logic                  i_output_last,
    output logic                  o_tready,
    output logic [NUM_CH-1:0]     o_lanes,
    output logic                  o_enb,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    // One extra bit so a completely full buffer (count == DEPTH) fits.
    localparam int unsigned CW = AW + 1;

    state_t                r_state;
    logic                  r_armed;
    logic                  r_tready;
    logic                  r_enb;
    logic                  r_overflow;
    logic [CW-1:0]         r_wcount;
    logic [CW-1:0]         r_count;
    logic [AW-1:0]         r_raddr;
    logic [REP_WIDTH-1:0]  r_rep;

    logic                  w_accept;
    logic                  w_room;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_last_rd;
    logic [CW-1:0]         w_count_final;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_unused_rd;

    assign w_accept      = i_tdata_valid && r_tready && (r_state == ST_LOAD);
    assign w_room        = (r_wcount < CW'(DEPTH));
    assign w_wr_en       = w_accept && w_room;
    assign w_rd_en       = (r_state == ST_SEND);
    assign w_last_rd     = ({1'b0, r_raddr} == (r_count - 1'b1));
    // Stored word count including the beat being accepted now, capped at DEPTH.
    assign w_count_final = w_room ? (r_wcount + 1'b1) : r_wcount;

    clk_pattern_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wcount[AW-1:0]),
        .i_wr_data (i_tdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_raddr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b1;
            r_tready   <= 1'b0;
            r_enb      <= 1'b0;
            r_overflow <= 1'b0;
            r_wcount   <= '0;
            r_count    <= '0;
            r_raddr    <= '0;
            r_rep      <= '0;
        end else begin
            // A read issued in SEND shows up on the RAM output next cycle.
            r_enb <= (r_state == ST_SEND);

            case (r_state)
                ST_IDLE: begin
                    // A done pulse seen in IDLE starts the load immediately.
                    if (r_armed || i_output_last) begin
                        r_state <= ST_START_REQ;
                    end
                end
                ST_START_REQ: begin
                    r_wcount   <= '0;
                    r_overflow <= 1'b0;
                    r_tready   <= 1'b1;
                    r_state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_room) begin
                            r_wcount <= r_wcount + 1'b1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        if (i_tdata_last) begin
                            r_count  <= w_count_final;
                            r_rep    <= i_repeat;
                            r_tready <= 1'b0;
                            r_raddr  <= '0;
                            r_armed  <= 1'b0;
                            r_state  <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (w_last_rd) begin
                        if (r_rep != '0) begin
                            r_raddr <= '0;
                            r_rep   <= r_rep - 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_raddr <= r_raddr + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // A done pulse always wins over the clear on entry to SEND.
            if (i_output_last) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Bits above NUM_CH are buffered but never replayed.
    assign w_unused_rd = ^w_rd_data;

    assign o_tready   = r_tready;
    assign o_lanes    = w_rd_data[NUM_CH-1:0];
    assign o_enb      = r_enb;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_overflow = r_overflow;

endmodule : clk_pattern_player
`default_nettype wire

// File: doc/clk_pattern_player.md
CLK_PATTERN_PLAYER -- requirements
Module: clk_pattern_player

Interface
REQ-001 Parameter DATA_WIDTH, default 8: input word width in bits.
REQ-002 Parameter NUM_CH, default 2: output lane count, 1..DATA_WIDTH.
REQ-003 Parameter DEPTH, default 64: pattern buffer words, power of two, >=2.
REQ-004 Parameter REP_WIDTH, default 8: width of the repeat count.
REQ-005 i_clk  in  1  single clock; all logic on its rising edge.
REQ-006 i_rst_n  in  1  reset, synchronous, active-low.
REQ-007 i_tdata_valid  in  1  input beat valid.
REQ-008 i_tdata  in  DATA_WIDTH  input pattern word.
REQ-009 i_tdata_last  in  1  final beat of the pattern.
REQ-010 i_repeat  in  REP_WIDTH  extra replays after the first pass; sampled on the accepted last beat.
REQ-011 i_output_last  in  1  consumer-done pulse; re-arms loading.
REQ-012 o_tready  out  1  block accepts beats.
REQ-013 o_lanes  out  NUM_CH  replayed pattern, bits [NUM_CH-1:0] of each stored word.
REQ-014 o_enb  out  1  o_lanes carries valid pattern data this cycle.
REQ-015 o_busy  out  1  high in any state other than IDLE.
REQ-016 o_overflow  out  1  sticky: beats were dropped because the buffer was full.

Function
REQ-017 The FSM SHALL have states IDLE, START_REQ, LOAD and SEND.
REQ-018 The block SHALL be armed after reset and after any cycle with i_output_last=1; arming SHALL clear on entering SEND.
REQ-019 IDLE->START_REQ when armed; otherwise IDLE holds.
REQ-020 START_REQ SHALL last one cycle, clear word count, write pointer and o_overflow, and go to LOAD; o_tready SHALL be 1 from the cycle after START_REQ until the cycle after the last beat is accepted.
REQ-021 Beat accepted = i_tdata_valid && o_tready; the first DEPTH accepted beats SHALL be written at addresses 0..DEPTH-1.
REQ-022 Accepted beats beyond DEPTH SHALL be dropped and set o_overflow; o_tready SHALL remain 1 until last.
REQ-023 Accepted beat with i_tdata_last=1: store (if room), latch count = min(beats, DEPTH) and rep = i_repeat, then go to SEND.
REQ-024 In SEND, the read address SHALL start at 0 and increment each cycle; after count-1 it SHALL wrap to 0 while rep>0 (rep decrements on wrap), else go to IDLE.
REQ-025 Read latency SHALL be 1: word at address a, read in cycle T, appears on o_lanes in T+1 with o_enb=1.
REQ-026 o_enb SHALL be high for exactly count*(rep+1) consecutive cycles with no gap at wrap points.
REQ-027 o_lanes SHALL hold its last value while o_enb=0.
REQ-028 The buffer SHALL NOT be consumed by replay; contents persist until overwritten by the next LOAD.
REQ-029 i_output_last during LOAD or SEND SHALL only set the arm flag; the current operation SHALL complete.
REQ-030 i_tdata_valid outside LOAD SHALL be ignored.
REQ-031 Counters SHALL be $clog2(DEPTH)+1 bits wide so count=DEPTH is representable; REP_WIDTH-bit rep SHALL not wrap below 0.

Reset
REQ-032 With i_rst_n=0 at a clock edge: state=IDLE, armed=1, o_tready=0, o_enb=0, o_lanes=0, o_overflow=0, o_busy=0, all pointers/counters=0.
REQ-033 Reset mid-LOAD or mid-SEND SHALL abort immediately; buffer contents are undefined afterwards and are not required to be cleared.

Structure
REQ-034 Package clk_pattern_pkg SHALL hold the FSM state enum and the default parameter localparams.
REQ-035 Buffer SHALL be a sub-module clk_pattern_ram: simple dual-port, one write port and one registered read port, depth DEPTH, width DATA_WIDTH, no vendor IP.
REQ-036 Target size: 120-400 lines of RTL including the RAM.

Verification
REQ-037 Reset, load 4 beats 0x01,0x02,0x03,0x00 with last on the 4th, i_repeat=0 -> o_enb high 4 cycles, o_lanes=1,2,3,0, then IDLE, o_busy=0.
REQ-038 Same 4 beats, i_repeat=2 -> o_enb high 12 consecutive cycles, lanes 1,2,3,0 three times with no gap.
REQ-039 DEPTH=64, send 70 beats -> o_overflow=1, exactly 64 words replayed, o_tready=0 the cycle after last.
REQ-040 Single beat 0x03 with last, i_repeat=0 -> o_enb high one cycle with o_lanes=3; no re-load until i_output_last pulsed, then o_tready returns 2 cycles later.
REQ-041 Assert i_rst_n=0 for one cycle mid-SEND -> o_enb=0 and state=IDLE the next cycle; block re-arms and loads a new pattern correctly.
REQ-042 Gapped i_tdata_valid (every other cycle) during LOAD -> only valid beats stored; replay order matches input order.
